// File: rtl/div_seq_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The master side requests a divide and the slave side (the divider) returns the result.
interface div_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_start;
    logic             in_signed;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;
    logic [WIDTH-1:0] out_quotient;
    logic [WIDTH-1:0] out_remainder;
    logic             out_busy;
    logic             out_done;
    logic             out_div_by_zero;

    modport master (
        output in_start, in_signed, in_dividend, in_divisor,
        input  out_quotient, out_remainder, out_busy, out_done, out_div_by_zero
    );

    modport slave (
        input  in_start, in_signed, in_dividend, in_divisor,
        output out_quotient, out_remainder, out_busy, out_done, out_div_by_zero
    );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle non-restoring divider: one add/subtract of a WIDTH+1-bit partial
// remainder per cycle, signed or unsigned, with start/busy/done handshake.
module div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input logic       in_clk,
    input logic       in_reset_n,
    div_seq_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] q_out_q, q_out_d;
    logic [WIDTH-1:0] r_out_q, r_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic             dvd_neg, dsr_neg;
    logic [WIDTH-1:0] dvd_mag, dsr_mag;
    logic [WIDTH:0]   shifted, step, fixed;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        q_out_d = q_out_q;
        r_out_d = r_out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        dvd_neg = bus.in_signed & bus.in_dividend[WIDTH-1];
        dsr_neg = bus.in_signed & bus.in_divisor[WIDTH-1];
        dvd_mag = dvd_neg ? -bus.in_dividend : bus.in_dividend;
        dsr_mag = dsr_neg ? -bus.in_divisor : bus.in_divisor;

        // Remainder sign before the shift picks subtract vs. add-back.
        shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        step    = rem_q[WIDTH] ? shifted + {1'b0, dsr_q} : shifted - {1'b0, dsr_q};
        fixed   = rem_q[WIDTH] ? rem_q + {1'b0, dsr_q} : rem_q;

        unique case (state_q)
            StIdle: begin
                // done_q high means this is the completion cycle; starts are dropped there.
                if (bus.in_start && !done_q) begin
                    busy_d = 1'b1;
                    dbz_d  = 1'b0;
                    cnt_d  = '0;
                    rem_d  = '0;
                    quo_d  = dvd_mag;
                    dsr_d  = dsr_mag;
                    qneg_d = dvd_neg ^ dsr_neg;
                    rneg_d = dvd_neg;
                    if (bus.in_divisor == '0) begin
                        q_out_d = '1;
                        r_out_d = bus.in_dividend;
                        state_d = StDone;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                rem_d = step;
                quo_d = {quo_q[WIDTH-2:0], ~step[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = StFix;
                end
            end
            StFix: begin
                q_out_d = qneg_q ? -quo_q : quo_q;
                r_out_d = rneg_q ? -fixed[WIDTH-1:0] : fixed[WIDTH-1:0];
                state_d = StDone;
            end
            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                dbz_d   = (dsr_q == '0);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            q_out_q <= '0;
            r_out_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.out_quotient    = q_out_q;
    assign bus.out_remainder   = r_out_q;
    assign bus.out_busy        = busy_q;
    assign bus.out_done        = done_q;
    assign bus.out_div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed spec cases plus randomized operands
// compared against a plain-arithmetic reference model.
module tb_div_seq;
    localparam int W = 32;
    localparam int NDIR = 8;
    localparam logic        DS [NDIR] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [31:0] DA [NDIR] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFF,
                                          32'h8000_0000, 32'd9, 32'hFFFF_FF9C, 32'd5};
    localparam logic [31:0] DB [NDIR] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd2,
                                          32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFF9, 32'd9};
    localparam logic [31:0] DQ [NDIR] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h7FFF_FFFF,
                                          32'h8000_0000, 32'd3, 32'd14, 32'd0};
    localparam logic [31:0] DR [NDIR] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd1,
                                          32'd0, 32'd0, 32'hFFFF_FFFE, 32'd5};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    div_seq_if #(.WIDTH(W)) bus ();

    div_seq #(.WIDTH(W)) dut (
        .in_clk     (clk),
        .in_reset_n (rst_n),
        .bus        (bus)
    );

    // Reference: truncating division, remainder follows dividend, special cases from the rules.
    function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        z = 1'b0;
        if (b == 0) begin
            q = '1; r = a; z = 1'b1;
        end else if (!s) begin
            q = a / b; r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = '0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
    endfunction

    // Issue one request and wait for done; hs_ok records busy/done handshake correctness.
    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int poke, output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic z, output int lat, output logic hs_ok);
        bus.in_signed   = s;
        bus.in_dividend = a;
        bus.in_divisor  = b;
        bus.in_start    = 1'b1;
        @(posedge clk); #1;
        bus.in_start    = 1'b0;
        bus.in_dividend = $urandom;
        bus.in_divisor  = $urandom;
        bus.in_signed   = 1'($urandom);
        lat   = -1;
        hs_ok = 1'b1;
        for (int k = 0; k < 100 && lat < 0; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (bus.out_done === 1'b1) begin
                lat = k;
                if (bus.out_busy !== 1'b0) hs_ok = 1'b0;
            end else begin
                if (bus.out_busy !== 1'b1) hs_ok = 1'b0;
                if (poke != 0 && k == poke) begin
                    bus.in_start    = 1'b1;
                    bus.in_dividend = $urandom;
                    bus.in_divisor  = $urandom_range(1, 50);
                end else begin
                    bus.in_start = 1'b0;
                end
            end
        end
        bus.in_start = 1'b0;
        q = bus.out_quotient;
        r = bus.out_remainder;
        z = bus.out_div_by_zero;
        @(posedge clk); #1;
        if (bus.out_done !== 1'b0) hs_ok = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        checks++;
        if (bus.out_quotient !== '0 || bus.out_remainder !== '0 || bus.out_busy !== 1'b0 ||
            bus.out_done !== 1'b0 || bus.out_div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset: got q=%h r=%h busy=%b done=%b dbz=%b, want all zero",
                     bus.out_quotient, bus.out_remainder, bus.out_busy, bus.out_done,
                     bus.out_div_by_zero);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [W-1:0] q, r;
        logic z, ok;
        int lat;
        for (int i = 0; i < NDIR; i++) begin
            run_op(DS[i], DA[i], DB[i], 0, q, r, z, lat, ok);
            checks++;
            if (q !== DQ[i] || r !== DR[i]) begin
                errors++;
                $display("FAIL directed[%0d] result: got q=%h r=%h, want q=%h r=%h",
                         i, q, r, DQ[i], DR[i]);
            end
            checks++;
            if (z !== 1'b0 || lat !== W + 2 || ok !== 1'b1) begin
                errors++;
                $display("FAIL directed[%0d] timing: got dbz=%b lat=%0d hs=%b, want 0 %0d 1",
                         i, z, lat, ok, W + 2);
            end
        end
    endtask

    task automatic test_div_by_zero;
        logic [W-1:0] q, r;
        logic z, ok;
        int lat;
        run_op(1'b0, 32'h1234, '0, 0, q, r, z, lat, ok);
        checks++;
        if (q !== 32'hFFFF_FFFF || r !== 32'h1234 || z !== 1'b1 || lat !== 1 || ok !== 1'b1) begin
            errors++;
            $display("FAIL dbz_unsigned: got q=%h r=%h dbz=%b lat=%0d hs=%b, want ffffffff 1234 1 1 1",
                     q, r, z, lat, ok);
        end
        run_op(1'b1, 32'hFFFF_FF00, '0, 0, q, r, z, lat, ok);
        checks++;
        if (q !== 32'hFFFF_FFFF || r !== 32'hFFFF_FF00 || z !== 1'b1 || lat !== 1) begin
            errors++;
            $display("FAIL dbz_signed: got q=%h r=%h dbz=%b lat=%0d, want ffffffff ffffff00 1 1",
                     q, r, z, lat);
        end
        run_op(1'b0, 32'd100, 32'd7, 0, q, r, z, lat, ok);
        checks++;
        if (z !== 1'b0 || q !== 32'd14 || r !== 32'd2) begin
            errors++;
            $display("FAIL dbz_clear: got dbz=%b q=%h r=%h, want 0 0000000e 00000002", z, q, r);
        end
    endtask

    task automatic test_busy_ignore;
        logic [W-1:0] q, r;
        logic z, ok;
        int lat;
        run_op(1'b0, 32'd1000, 32'd7, 10, q, r, z, lat, ok);
        checks++;
        if (q !== 32'd142 || r !== 32'd6 || lat !== W + 2 || ok !== 1'b1) begin
            errors++;
            $display("FAIL busy_ignore: got q=%h r=%h lat=%0d hs=%b, want 0000008e 00000006 %0d 1",
                     q, r, lat, ok, W + 2);
        end
    endtask

    task automatic test_back_to_back;
        logic seen;
        bus.in_signed   = 1'b0;
        bus.in_dividend = 32'd20;
        bus.in_divisor  = 32'd6;
        bus.in_start    = 1'b1;
        @(posedge clk); #1;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(posedge clk); #1;
            seen = bus.out_done;
        end
        checks++;
        if (seen !== 1'b1 || bus.out_quotient !== 32'd3 || bus.out_remainder !== 32'd2) begin
            errors++;
            $display("FAIL b2b_first: got done=%b q=%h r=%h, want 1 00000003 00000002",
                     seen, bus.out_quotient, bus.out_remainder);
        end
        bus.in_dividend = 32'd50;
        bus.in_divisor  = 32'd7;
        @(posedge clk); #1;
        checks++;
        if (bus.out_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_cycle_start: got busy=%b, want 0", bus.out_busy);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_reaccept: got busy=%b, want 1", bus.out_busy);
        end
        bus.in_start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(posedge clk); #1;
            seen = bus.out_done;
        end
        checks++;
        if (seen !== 1'b1 || bus.out_quotient !== 32'd7 || bus.out_remainder !== 32'd1) begin
            errors++;
            $display("FAIL b2b_second: got done=%b q=%h r=%h, want 1 00000007 00000001",
                     seen, bus.out_quotient, bus.out_remainder);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic [W-1:0] a, b, q, r, eq, er;
        logic s, z, ez, ok;
        int lat;
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom);
            a = (i % 9 == 4) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = $urandom_range(1, 15);
                3:       b = -$urandom_range(1, 15);
                4:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            model(s, a, b, eq, er, ez);
            run_op(s, a, b, 0, q, r, z, lat, ok);
            checks++;
            if (q !== eq || r !== er || z !== ez) begin
                errors++;
                $display("FAIL random[%0d] s=%b a=%h b=%h: got q=%h r=%h dbz=%b, want q=%h r=%h dbz=%b",
                         i, s, a, b, q, r, z, eq, er, ez);
            end
            checks++;
            if (lat !== (ez ? 1 : W + 2) || ok !== 1'b1) begin
                errors++;
                $display("FAIL random[%0d] timing: got lat=%0d hs=%b, want %0d 1",
                         i, lat, ok, ez ? 1 : W + 2);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] q, r;
        logic z, ok;
        int lat;
        bus.in_signed   = 1'b0;
        bus.in_dividend = 32'd12345;
        bus.in_divisor  = 32'd17;
        bus.in_start    = 1'b1;
        @(posedge clk); #1;
        bus.in_start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (bus.out_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got busy=%b, want 1", bus.out_busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_quotient !== '0 || bus.out_remainder !== '0 || bus.out_busy !== 1'b0 ||
            bus.out_done !== 1'b0 || bus.out_div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got q=%h r=%h busy=%b done=%b dbz=%b, want all zero",
                     bus.out_quotient, bus.out_remainder, bus.out_busy, bus.out_done,
                     bus.out_div_by_zero);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(1'b0, 32'd9, 32'd3, 0, q, r, z, lat, ok);
        checks++;
        if (q !== 32'd3 || r !== 32'd0 || z !== 1'b0 || lat !== W + 2 || ok !== 1'b1) begin
            errors++;
            $display("FAIL after_reset: got q=%h r=%h dbz=%b lat=%0d hs=%b, want 3 0 0 %0d 1",
                     q, r, z, lat, ok, W + 2);
        end
    endtask

    initial begin
        bus.in_start    = 1'b0;
        bus.in_signed   = 1'b0;
        bus.in_dividend = '0;
        bus.in_divisor  = '0;
        #3;
        test_reset();
        test_directed();
        test_div_by_zero();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
